booth_seq_mult: RTL and testbench

Sequential radix-2 Booth multiplier core with valid/ready handshakes on both sides. It accepts one pair of signed operands, runs one Booth iteration per clock under an internal iteration counter, and holds the signed product until the downstream consumer takes it. It is the top-level compute block of the Booth multiplier path. The iteration counter with its terminal-count detect sets the completion point.

---
 rtl/booth_seq_mult.sv | 57 +++++
 tb/tb_booth_seq_mult.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth signed multiplier, one step per clock,
// valid/ready on operands and product.
module booth_seq_mult #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] m_reg, q_reg;
    logic [WIDTH:0]   a_reg, sum;
    logic             q_m1, last;
    logic [CNT_W-1:0] count;
    assign last      = count == CNT_W'(WIDTH - 1);
    assign in_ready  = state == IDLE && !reset;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    always_comb begin
        sum = {q_reg[0], q_m1} == 2'b01 ? a_reg + {m_reg[WIDTH-1], m_reg} :
              {q_reg[0], q_m1} == 2'b10 ? a_reg - {m_reg[WIDTH-1], m_reg} : a_reg;
        state_next = state;
        state_next = reset           ? IDLE :
                     state == IDLE   ? (in_valid ? BUSY : IDLE) :
                     state == BUSY   ? (last ? DONE : BUSY) :
                     out_ready       ? IDLE : DONE;
    end
    always_ff @(posedge clk) state <= state_next;
    // {A,Q,q_m1} shifted right by one after the add: A takes sum>>>1, Q takes sum[0] on top
    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
            count   <= '0;
        end else if (state == IDLE && in_valid) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            q_m1  <= 1'b0;
            count <= '0;
        end else if (state == BUSY) begin
            a_reg <= {sum[WIDTH], sum[WIDTH:1]};
            q_reg <= {sum[0], q_reg[WIDTH-1:1]};
            q_m1  <= q_reg[0];
            count <= last ? count : count + 1'b1;
            if (last) product <= {sum, q_reg[WIDTH-1:1]};
        end
    end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed and randomised checks of booth_seq_mult (WIDTH=16)
// against signed multiplication computed in the bench.
module tb_booth_seq_mult;
    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [15:0] multiplicand = 0, multiplier = 0;
    logic        in_ready, out_valid, busy;
    logic [31:0] product;
    int          checks = 0, errors = 0, cyc = 0, last_acc = 0;

    booth_seq_mult #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // starts and ends just after a falling edge
    task automatic accept(input logic [15:0] m, input logic [15:0] q);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1; multiplicand = m; multiplier = q;
        @(negedge clk);
        in_valid = 0;
        last_acc = cyc;
    endtask

    task automatic wait_done(input string tag);
        int  lat = 0;
        logic b = 1;
        while (!out_valid && lat < 40) begin
            b &= busy;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd16);
        chk({tag, "_busy_throughout"}, 32'(b & busy), 32'd1);
    endtask

    task automatic mult(input string tag, input logic [15:0] m, input logic [15:0] q,
                        input int stall, input logic [31:0] exp);
        accept(m, q);
        wait_done(tag);
        chk({tag, "_product"}, product, exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_product"}, product, exp);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int a0;
        logic [15:0] rm, rq;
        logic [15:0] corners [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
        // reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", product, 32'd0);
        reset = 0;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // 3 x 5, held in DONE for two cycles
        mult("3x5", 16'd3, 16'd5, 2, 32'h0000000F);

        // back-to-back with out_ready high: second accept 18 cycles after first
        out_ready = 1;
        accept(16'hFFF9, 16'd6);
        a0 = last_acc;
        wait_done("m7x6");
        chk("m7x6_product", product, 32'hFFFFFFD6);
        @(negedge clk);
        chk("m7x6_one_cycle_valid", 32'(out_valid), 32'd0);
        accept(16'h8000, 16'h8000);
        chk("accept_spacing", 32'(last_acc - a0), 32'd18);
        wait_done("min_sq");
        chk("min_sq_product", product, 32'h40000000);
        @(negedge clk);
        out_ready = 0;
        chk("min_sq_one_cycle_valid", 32'(out_valid), 32'd0);

        // backpressure for 5 cycles
        mult("max_x_min", 16'h7FFF, 16'h8000, 5, 32'hC0008000);

        // operand changes and a stray in_valid during BUSY are ignored
        accept(16'd12, 16'hFFF4);
        multiplicand = 16'd99; multiplier = 16'd77;
        repeat (3) @(negedge clk);
        chk("busy_in_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1; multiplicand = 16'd5; multiplier = 16'd9;
        @(negedge clk);
        in_valid = 0;
        multiplicand = 16'h1234;
        begin
            int lat = 4;
            while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
            chk("ignore_latency", 32'(lat), 32'd16);
        end
        chk("ignore_product", product, 32'hFFFFFF70);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("ignore_no_requeue", 32'(busy), 32'd0);
        chk("product_held_after_consume", product, 32'hFFFFFF70);

        // reset in the middle of BUSY
        accept(16'd1234, 16'd567);
        repeat (7) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_product", product, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        reset = 0;
        begin
            logic seen = 0;
            for (int i = 0; i < 20; i++) begin @(negedge clk); seen |= out_valid; end
            chk("midrst_no_valid", 32'(seen), 32'd0);
        end
        mult("2x2", 16'd2, 16'd2, 0, 32'h00000004);

        // corner pairs then random pairs with random stalls
        for (int i = 0; i < 25; i++) begin
            rm = corners[i / 5]; rq = corners[i % 5];
            mult("corner", rm, rq, i % 3, 32'(longint'($signed(rm)) * longint'($signed(rq))));
        end
        for (int i = 0; i < 300; i++) begin
            rm = 16'($urandom); rq = 16'($urandom);
            mult("rand", rm, rq, int'($urandom_range(0, 3)),
                 32'(longint'($signed(rm)) * longint'($signed(rq))));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
